unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port block RAM between an
// instruction-fetch read port and a data-memory read/write port.
// Data requests win by default. Defining ARB_STARVE_GUARD_EN adds a fetch
// starvation guard that forces a fetch grant after STARVE_MAX consecutive
// contested data grants.
module unified_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  // Instruction fetch port
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // Data memory port
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  // Block RAM port
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  // Fetch stall statistics
  output logic [15:0]     stall_cnt
);

  typedef enum logic [1:0] {
    OwnNone,
    OwnIf,
    OwnDmRd
  } owner_e;

  owner_e      owner_q;
  logic [15:0] stall_q;
  logic        dm_win;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;
  logic       force_if;

  // Fetch is forced through once it has lost STARVE_MAX contested cycles in a row
  always_comb begin
    force_if = (starve_q == 4'(STARVE_MAX));
    dm_win   = dm_req & ~(if_req & force_if);
  end

  // Count consecutive cycles in which fetch waited behind a data grant
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      starve_q <= 4'd0;
    end else if (if_gnt) begin
      starve_q <= 4'd0;
    end else if (if_req && dm_gnt && (starve_q < 4'(STARVE_MAX))) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  // Strict data priority
  always_comb begin
    dm_win = dm_req;
  end
`endif

  // Grants and RAM port mux; everything is forced quiet while in reset
  always_comb begin
    dm_gnt    = ~sys_rst & dm_win;
    if_gnt    = ~sys_rst & if_req & ~dm_win;
    mem_en    = if_gnt | dm_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      if (dm_we) begin
        mem_we = dm_be;
      end
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Remember which port owns the read data returning next cycle
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      owner_q <= OwnNone;
    end else if (dm_gnt && !dm_we) begin
      owner_q <= OwnDmRd;
    end else if (if_gnt) begin
      owner_q <= OwnIf;
    end else begin
      owner_q <= OwnNone;
    end
  end

  // Saturating count of cycles in which a fetch request was denied
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stall_q <= 16'd0;
    end else if (if_req && !if_gnt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  // Route RAM read data to the owning port; data is zero when not valid
  always_comb begin
    if_rvalid = (owner_q == OwnIf);
    dm_rvalid = (owner_q == OwnDmRd);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a write-first
// byte-enabled RAM model. Initial RAM word i = {8'hA0, i, 8'h5A, i}.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [3:0]    dm_be = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram [256];

  unified_mem_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE_MAX(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_rvalid(dm_rvalid),
    .dm_rdata (dm_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = {8'hA0, 8'(i), 8'h5A, 8'(i)};
    end
  end

  // Write-first single-port RAM
  always @(posedge sys_clk) begin
    logic [31:0] w;
    if (mem_en) begin
      w = ram[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
      ram[mem_addr[9:2]] <= w;
      mem_rdata <= w;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // Reset with both requests raised: nothing may leak out
    if_req = 1'b1;
    dm_req = 1'b1;
    #2;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // Back-to-back fetches 0x0, 0x4, 0x8
    if_req  = 1'b1;
    if_addr = 32'h0;
    #1;
    check("f0_if_gnt", 32'(if_gnt), 32'd1);
    check("f0_mem_en", 32'(mem_en), 32'd1);
    check("f0_mem_addr", mem_addr, 32'h0);
    tick();
    check("f0_rvalid", 32'(if_rvalid), 32'd1);
    check("f0_rdata", if_rdata, 32'hA0005A00);
    if_addr = 32'h4;
    #1;
    check("f1_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    check("f1_rvalid", 32'(if_rvalid), 32'd1);
    check("f1_rdata", if_rdata, 32'hA0015A01);
    if_addr = 32'h8;
    #1;
    check("f2_mem_addr", mem_addr, 32'h8);
    tick();
    check("f2_rvalid", 32'(if_rvalid), 32'd1);
    check("f2_rdata", if_rdata, 32'hA0025A02);
    if_req = 1'b0;
    tick();
    check("f_idle_rvalid", 32'(if_rvalid), 32'd0);
    check("f_idle_rdata", if_rdata, 32'd0);

    // Contested read: data wins, fetch stalls once
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h100;
    if_req  = 1'b1;
    if_addr = 32'hC;
    #1;
    check("c_dm_gnt", 32'(dm_gnt), 32'd1);
    check("c_if_gnt", 32'(if_gnt), 32'd0);
    check("c_mem_addr", mem_addr, 32'h100);
    check("c_mem_we", 32'(mem_we), 32'd0);
    tick();
    dm_req = 1'b0;
    if_req = 1'b0;
    check("c_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check("c_dm_rdata", dm_rdata, 32'hA0405A40);
    check("c_if_rvalid", 32'(if_rvalid), 32'd0);
    check("c_stall", 32'(stall_cnt), 32'd1);

    // Partial write then read-back of the same word
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b0011;
    dm_addr  = 32'h200;
    dm_wdata = 32'hDEADBEEF;
    #1;
    check("w_dm_gnt", 32'(dm_gnt), 32'd1);
    check("w_mem_we", 32'(mem_we), 32'h3);
    check("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    check("w_no_rvalid", 32'(dm_rvalid), 32'd0);
    dm_we = 1'b0;
    dm_be = 4'b0000;
    #1;
    check("r_mem_we", 32'(mem_we), 32'd0);
    tick();
    dm_req = 1'b0;
    check("r_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check("r_dm_rdata", dm_rdata, 32'hA080BEEF);

    // Sustained contention from a clean reset
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tick();
    dm_req  = 1'b1;
    dm_addr = 32'h10;
    if_req  = 1'b1;
    if_addr = 32'h20;
    #1;
    for (int c = 0; c < 10; c++) begin
`ifdef ARB_STARVE_GUARD_EN
      check($sformatf("s_if_gnt_%0d", c), 32'(if_gnt), 32'((c % 5) == 4));
      check($sformatf("s_dm_gnt_%0d", c), 32'(dm_gnt), 32'((c % 5) != 4));
`else
      check($sformatf("s_if_gnt_%0d", c), 32'(if_gnt), 32'd0);
      check($sformatf("s_dm_gnt_%0d", c), 32'(dm_gnt), 32'd1);
`endif
      tick();
    end
`ifdef ARB_STARVE_GUARD_EN
    check("s_stall", 32'(stall_cnt), 32'd8);
`else
    check("s_stall", 32'(stall_cnt), 32'd10);
`endif
    dm_req = 1'b0;
    if_req = 1'b0;
    tick();

    // Reset landing while a fetch response is outstanding
    if_req  = 1'b1;
    if_addr = 32'h4;
    #1;
    check("x_if_gnt", 32'(if_gnt), 32'd1);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("x_if_rvalid", 32'(if_rvalid), 32'd0);
    check("x_if_rdata", if_rdata, 32'd0);
    check("x_if_gnt_rst", 32'(if_gnt), 32'd0);
    check("x_mem_en_rst", 32'(mem_en), 32'd0);
    tick();
    check("x_stall", 32'(stall_cnt), 32'd0);
    check("x_if_gnt_rst2", 32'(if_gnt), 32'd0);
    if_req  = 1'b0;
    sys_rst = 1'b0;
    tick();
    check("x_post_rvalid", 32'(if_rvalid), 32'd0);
    check("x_post_dm_rvalid", 32'(dm_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
